cla_chain_adder: RTL

- Sequential multi-word adder built around the existing 7-bit `cla_adder`.
- Accepts operand word pairs on a valid/ready stream, least significant word first.
- Holds the inter-word carry in a register and feeds `cla_adder` with the held carry as `cin`.
- Registers each sum word onto an output valid/ready stream; extends precision to up to `MAX_WORDS` x 7 bits.

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_adder.sv | 37 +++
 rtl/cla_chain_adder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types for the chained carry-lookahead adder.
package cla_pkg;

   localparam int WORD_W = 7;

   typedef enum logic {
      IDLE,
      CHAIN
   } chain_state_t;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/cla_adder.sv
// 7-bit carry-lookahead adder; every carry is a flat generate/propagate sum.
module cla_adder
   import cla_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] s,
   output logic              cout
);

   logic [WORD_W-1:0] g;
   logic [WORD_W-1:0] p;
   logic [WORD_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      logic pp;
      c = '0;
      c[0] = cin;
      for (int i = 0; i < WORD_W; i++) begin
         c[i+1] = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & cin);
      end
   end

   assign s    = p ^ c[WORD_W-1:0];
   assign cout = c[WORD_W];

endmodule

// File: rtl/cla_chain_adder.sv
// Streams multi-word sums through one cla_adder, carrying between words.
// Define CLA_CHAIN_OVF_EN to add the signed-overflow output out_ovf.
module cla_chain_adder
   import cla_pkg::*;
#(
   parameter int MAX_WORDS = 8,
   parameter int IDX_W     = $clog2(MAX_WORDS)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WORD_W-1:0] in_a,
   input  logic [WORD_W-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WORD_W-1:0] out_s,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_cout,
   output logic             out_err
`ifdef CLA_CHAIN_OVF_EN
  ,output logic             out_ovf
`endif
);

   chain_state_t     state_q, state_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             out_valid_q, out_valid_d;
   word_t            out_s_q, out_s_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             out_cout_q, out_cout_d;
   logic             out_err_q, out_err_d;
`ifdef CLA_CHAIN_OVF_EN
   logic             out_ovf_q, out_ovf_d;
`endif

   logic             accept;
   logic             sel_cin;
   word_t            sum;
   logic             cout;
   logic [IDX_W-1:0] word_idx;
   logic             at_max;
   logic             last_eff;
   logic             err;

   cla_adder u_add (
      .a    (in_a),
      .b    (in_b),
      .cin  (sel_cin),
      .s    (sum),
      .cout (cout)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      sel_cin = 1'b0;
      unique case (state_q)
         IDLE:  sel_cin = in_first ? in_cin : 1'b0;
         CHAIN: sel_cin = in_first ? in_cin : carry_q;
      endcase

      // A first word always restarts at index 0, even mid-chain.
      word_idx = (in_first || state_q == IDLE) ? '0 : idx_q;
      at_max   = (word_idx == IDX_W'(MAX_WORDS - 1));
      last_eff = in_last || at_max;
      err      = (state_q == IDLE  && !in_first) ||
                 (state_q == CHAIN &&  in_first) ||
                 (at_max && !in_last);
   end

   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q && !out_ready;
      out_s_d     = out_s_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_cout_d  = out_cout_q;
      out_err_d   = out_err_q;
`ifdef CLA_CHAIN_OVF_EN
      out_ovf_d   = out_ovf_q;
`endif

      if (accept) begin
         out_valid_d = 1'b1;
         out_s_d     = sum;
         out_idx_d   = word_idx;
         out_last_d  = last_eff;
         out_cout_d  = last_eff ? cout : 1'b0;
         out_err_d   = err;
`ifdef CLA_CHAIN_OVF_EN
         // Overflow is carry into the sign bit differing from carry out.
         out_ovf_d   = last_eff ?
            (cout ^ (in_a[WORD_W-1] ^ in_b[WORD_W-1] ^ sum[WORD_W-1])) :
            1'b0;
`endif
         if (last_eff) begin
            state_d = IDLE;
            carry_d = 1'b0;
            idx_d   = '0;
         end else begin
            state_d = CHAIN;
            carry_d = cout;
            idx_d   = word_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_err_q   <= 1'b0;
`ifdef CLA_CHAIN_OVF_EN
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_cout_q  <= out_cout_d;
         out_err_q   <= out_err_d;
`ifdef CLA_CHAIN_OVF_EN
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;
   assign out_err   = out_err_q;
`ifdef CLA_CHAIN_OVF_EN
   assign out_ovf   = out_ovf_q;
`endif

endmodule
